led_status_engine: RTL and testbench
====================================

# led_status_engine

Parametrised LED/RGB status engine: the next-generation display back end for the board LEDs. It holds NUM_PAGES tear-free pages of LED data, each with a per-LED blink mask, and can auto-scroll between pages. It also drives NUM_RGB tri-colour LEDs with PWM brightness in off/solid/blink/breathe modes. Status producers (clock manager, power controller, demo sequencer) write pages through a valid/ready port; the block sits directly in front of the LED pins.

## Interface
- NUM_LEDS, 16, standard LEDs per page
- NUM_PAGES, 8, page count; power of two, ≥2
- NUM_RGB, 2, RGB LED count
- PWM_BITS, 8, PWM counter/duty width
- TICK_DIV, 100000, clk cycles per tick (1 ms at 100 MHz); ≥2
- BLINK_TICKS, 250, ticks per blink half-period
- SCROLL_TICKS, 1000, ticks per auto-scroll step
- PW = $clog2(NUM_PAGES) (derived)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- wr_valid  in  1  page write request
- wr_ready  out  1  write port can accept
- wr_page  in  PW  target page
- wr_data  in  NUM_LEDS  LED on-bits
- wr_blink  in  NUM_LEDS  per-LED blink enable
- page_sel  in  PW  manual page select
- auto_scroll  in  1  1 = auto-advance pages
- rgb_mode  in  2*NUM_RGB  per channel: 0 off, 1 solid, 2 blink, 3 breathe
- rgb_color  in  3*NUM_RGB  per channel {r,g,b} enables
- rgb_level  in  PWM_BITS*NUM_RGB  per-channel peak brightness
- led  out  NUM_LEDS  registered LED drive
- led_rgb  out  3*NUM_RGB  registered {r,g,b} per channel; channel i at [3i+2:3i]
- cur_page  out  PW  page currently displayed
- tick  out  1  one-cycle tick strobe

## Operation
- Prescaler counts 0..TICK_DIV-1. tick=1 in the cycle the count wraps.
- Blink phase toggles every BLINK_TICKS ticks. It is shared by the page LEDs and the RGB channels.
- Write port:
  - Accept when wr_valid && wr_ready. Page, data and blink are captured into one staging register, and wr_ready drops the next cycle.
  - Staged entry commits to page memory on the next tick strictly after the accept cycle. An accept coinciding with a tick waits for the following tick.
  - wr_ready rises the cycle after commit, so at most one write is outstanding. This gives tear-free updates.
- Page select:
  - With auto_scroll=0: cur_page follows page_sel with one cycle of latency.
  - With auto_scroll=1: cur_page advances every SCROLL_TICKS ticks and wraps NUM_PAGES-1→0.
  - On the 0→1 edge of auto_scroll, scrolling starts from the present cur_page with the scroll counter cleared.
- LED output: led = data[cur_page] & ~(blink[cur_page] & {NUM_LEDS{blink_phase}}). Blinking LEDs are dark while blink_phase=1.
- RGB channel state by mode:
  - Off: duty 0.
  - Solid: duty = level.
  - Blink: duty = level when blink_phase=0, else 0.
  - Breathe: a PWM_BITS triangle ramp steps ±1 per tick, reversing at 0 and at all-ones. duty = (level*ramp)>>PWM_BITS, computed at full 2*PWM_BITS width and keeping the upper half.
- PWM:
  - A free-running PWM_BITS counter is shared by all channels.
  - Channel on when counter < duty, so duty 0 is always dark and all-ones gives 255/256 on.
  - Colour bits are ANDed with the channel's on value.
- A mode change takes effect at the next duty computation. The breathe ramp keeps running in every mode, so no restart is needed.

## Timing
- Reset is asynchronous and active-high. While reset is asserted:
  - led=0, led_rgb=0, cur_page=0, tick=0, wr_ready=1.
  - Page memory, blink masks, staging register, prescaler, blink phase, scroll counter and ramp are cleared, with ramp direction set to up.
- Reset mid-write discards any staged entry.
- Latency:
  - page_sel→cur_page: 1 cycle.
  - cur_page/memory→led: 1 cycle.
  - Commit→led: 1 cycle after the commit tick, if the written page is displayed.
  - Mode/level→led_rgb: 2 cycles (duty register, then output register).
- A commit and a scroll step on the same tick are both applied. led reflects the new cur_page with the new data one cycle later.
- With a constant page_sel and auto_scroll=0, cur_page is stable.

## Structure
- Package led_status_pkg holds the rgb mode encodings (RGB_OFF/SOLID/BLINK/BREATHE) and the rgb_mode_t typedef.
- One sub-module, rgb_pwm_channel, instantiated NUM_RGB times. It takes mode, level, colour, blink_phase, tick and the shared PWM count, and owns its ramp, duty register and output register.
- The top level owns the prescaler, blink phase, staging, page memory, scroll logic and PWM counter.

## Test plan
- Reset with TICK_DIV=4 → all outputs zero, wr_ready=1. tick pulses every 4 cycles after reset release.
- Write page 0, data 16'h00FF, blink 0, on a non-tick cycle → wr_ready low until the next tick commits, then high. led=16'h00FF one cycle after the commit.
- Write blink 16'h000F on page 0 (data 16'h00FF), BLINK_TICKS=2 → led alternates 16'h00FF/16'h00F0 every 2 ticks.
- Write accepted in the same cycle as a tick → commit occurs on the following tick, not the current one.
- auto_scroll=1, NUM_PAGES=8, SCROLL_TICKS=1 → cur_page steps one page per tick and wraps 7→0. Deasserting with page_sel=3 → cur_page=3 next cycle.
- RGB channel 0: mode solid, colour 3'b100, level 64 → r high exactly 64 of every 256 cycles. Mode breathe with level 255 → ramp reaches 255 after 255 ticks, then descends.

Source files
------------

// File: rtl/led_status_pkg.sv
// Shared types for the LED/RGB status engine.
// RGB channel mode encodings.
package led_status_pkg;

  typedef enum logic [1:0] {
    RGB_OFF     = 2'd0,
    RGB_SOLID   = 2'd1,
    RGB_BLINK   = 2'd2,
    RGB_BREATHE = 2'd3
  } rgb_mode_t;

endpackage

// File: rtl/led_status_engine_rgb.sv
// One RGB status channel: breathe ramp, duty register and PWM output.
// The ramp free-runs in every mode so breathe never restarts.
module rgb_pwm_channel
  import led_status_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  rgb_mode_t           mode,
  input  logic [PWM_BITS-1:0] level,
  input  logic [2:0]          color,
  input  logic                blink_phase,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [2:0]          led_rgb
);

  logic [PWM_BITS-1:0]   ramp;
  logic                  ramp_up;
  logic [PWM_BITS-1:0]   duty;
  logic [PWM_BITS-1:0]   duty_nxt;
  logic [2*PWM_BITS-1:0] prod;
  logic [PWM_BITS-1:0]   breathe;

  assign prod    = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, ramp};
  assign breathe = PWM_BITS'(prod >> PWM_BITS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramp    <= '0;
      ramp_up <= 1'b1;
    end else if (tick) begin
      if (ramp_up) begin
        if (&ramp) begin
          ramp_up <= 1'b0;
          ramp    <= ramp - PWM_BITS'(1);
        end else begin
          ramp    <= ramp + PWM_BITS'(1);
        end
      end else begin
        if (ramp == '0) begin
          ramp_up <= 1'b1;
          ramp    <= ramp + PWM_BITS'(1);
        end else begin
          ramp    <= ramp - PWM_BITS'(1);
        end
      end
    end
  end

  always_comb begin
    duty_nxt = '0;
    unique case (1'b1)
      (mode == RGB_OFF):     duty_nxt = '0;
      (mode == RGB_SOLID):   duty_nxt = level;
      (mode == RGB_BLINK):   duty_nxt = blink_phase ? '0 : level;
      (mode == RGB_BREATHE): duty_nxt = breathe;
      default:               duty_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty    <= '0;
      led_rgb <= '0;
    end else begin
      duty    <= duty_nxt;
      led_rgb <= color & {3{pwm_cnt < duty}};
    end
  end

endmodule

// File: rtl/led_status_engine.sv
// Paged LED display with tear-free single-entry write staging,
// auto-scroll, shared blink phase and PWM-driven RGB channels.
module led_status_engine
  import led_status_pkg::*;
#(
  parameter int NUM_LEDS     = 16,
  parameter int NUM_PAGES    = 8,
  parameter int NUM_RGB      = 2,
  parameter int PWM_BITS     = 8,
  parameter int TICK_DIV     = 100000,
  parameter int BLINK_TICKS  = 250,
  parameter int SCROLL_TICKS = 1000,
  localparam int PW          = $clog2(NUM_PAGES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [PW-1:0]                wr_page,
  input  logic [NUM_LEDS-1:0]          wr_data,
  input  logic [NUM_LEDS-1:0]          wr_blink,
  input  logic [PW-1:0]                page_sel,
  input  logic                         auto_scroll,
  input  logic [2*NUM_RGB-1:0]         rgb_mode,
  input  logic [3*NUM_RGB-1:0]         rgb_color,
  input  logic [PWM_BITS*NUM_RGB-1:0]  rgb_level,
  output logic [NUM_LEDS-1:0]          led,
  output logic [3*NUM_RGB-1:0]         led_rgb,
  output logic [PW-1:0]                cur_page,
  output logic                         tick
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int BLK_W = $clog2(BLINK_TICKS + 1);
  localparam int SCR_W = $clog2(SCROLL_TICKS + 1);

  logic [PRE_W-1:0]    pre_cnt;
  logic [BLK_W-1:0]    blk_cnt;
  logic                blink_phase;
  logic [SCR_W-1:0]    scr_cnt;
  logic                auto_q;
  logic                stg_valid;
  logic [PW-1:0]       stg_page;
  logic [NUM_LEDS-1:0] stg_data;
  logic [NUM_LEDS-1:0] stg_blink;
  logic [NUM_LEDS-1:0] mem_data  [NUM_PAGES];
  logic [NUM_LEDS-1:0] mem_blink [NUM_PAGES];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                accept;
  logic                commit;

  assign tick     = pre_cnt == PRE_W'(TICK_DIV - 1);
  assign wr_ready = ~stg_valid;
  assign accept   = wr_valid & wr_ready;
  assign commit   = stg_valid & tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_cnt     <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blk_cnt == BLK_W'(BLINK_TICKS - 1)) begin
        blk_cnt     <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blk_cnt     <= blk_cnt + BLK_W'(1);
      end
    end
  end

  // A staged entry only becomes valid after its accept cycle, so an
  // accept on a tick naturally waits for the following tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_valid <= 1'b0;
      stg_page  <= '0;
      stg_data  <= '0;
      stg_blink <= '0;
    end else if (accept) begin
      stg_valid <= 1'b1;
      stg_page  <= wr_page;
      stg_data  <= wr_data;
      stg_blink <= wr_blink;
    end else if (commit) begin
      stg_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PAGES; p++) begin
        mem_data[p]  <= '0;
        mem_blink[p] <= '0;
      end
    end else if (commit) begin
      mem_data[stg_page]  <= stg_data;
      mem_blink[stg_page] <= stg_blink;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_page <= '0;
      scr_cnt  <= '0;
      auto_q   <= 1'b0;
    end else begin
      auto_q <= auto_scroll;
      if (!auto_scroll) begin
        cur_page <= page_sel;
        scr_cnt  <= '0;
      end else if (!auto_q) begin
        scr_cnt  <= '0;
      end else if (tick) begin
        if (scr_cnt == SCR_W'(SCROLL_TICKS - 1)) begin
          scr_cnt  <= '0;
          cur_page <= cur_page + PW'(1);
        end else begin
          scr_cnt  <= scr_cnt + SCR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led <= '0;
    end else begin
      led <= mem_data[cur_page]
           & ~(mem_blink[cur_page] & {NUM_LEDS{blink_phase}});
    end
  end

  for (genvar i = 0; i < NUM_RGB; i++) begin : g_rgb
    rgb_pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .mode        (rgb_mode_t'(rgb_mode[2*i +: 2])),
      .level       (rgb_level[PWM_BITS*i +: PWM_BITS]),
      .color       (rgb_color[3*i +: 3]),
      .blink_phase (blink_phase),
      .tick        (tick),
      .pwm_cnt     (pwm_cnt),
      .led_rgb     (led_rgb[3*i +: 3])
    );
  end

endmodule

// File: tb/tb_led_status_engine.sv
// Bench for led_status_engine: directed vectors and hand sequences,
// then random traffic against an arithmetic reference model.
module tb_led_status_engine;

  localparam int NL = 16;
  localparam int NP = 8;
  localparam int NR = 2;
  localparam int PB = 8;
  localparam int TD = 4;
  localparam int BT = 2;
  localparam int ST = 1;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [PW-1:0] wr_page = '0;
  logic [NL-1:0] wr_data = '0;
  logic [NL-1:0] wr_blink = '0;
  logic [PW-1:0] page_sel = '0;
  logic auto_scroll = 1'b0;
  logic [2*NR-1:0] rgb_mode = '0;
  logic [3*NR-1:0] rgb_color = '0;
  logic [PB*NR-1:0] rgb_level = '0;
  logic [NL-1:0] led;
  logic [3*NR-1:0] led_rgb;
  logic [PW-1:0] cur_page;
  logic tick;

  always #5 clk = ~clk;

  led_status_engine #(
    .NUM_LEDS(NL), .NUM_PAGES(NP), .NUM_RGB(NR), .PWM_BITS(PB),
    .TICK_DIV(TD), .BLINK_TICKS(BT), .SCROLL_TICKS(ST)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_page(wr_page),
    .wr_data(wr_data), .wr_blink(wr_blink),
    .page_sel(page_sel), .auto_scroll(auto_scroll),
    .rgb_mode(rgb_mode), .rgb_color(rgb_color), .rgb_level(rgb_level),
    .led(led), .led_rgb(led_rgb), .cur_page(cur_page), .tick(tick)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: cycle index since reset release drives all timing.
  int cyc;
  logic [NL-1:0] m_data [NP];
  logic [NL-1:0] m_blk [NP];
  bit m_pend;
  logic [PW-1:0] m_pg;
  logic [NL-1:0] m_d, m_b;
  logic [PW-1:0] m_cur;
  logic [NL-1:0] m_led;
  bit m_auto_q;
  int m_scr;
  int m_duty [NR];
  logic [3*NR-1:0] m_rgb;

  function automatic int tri_ramp(int t);
    int k;
    k = t % 510;
    return (k <= 255) ? k : 510 - k;
  endfunction

  function automatic bit phase(int n);
    return ((n / TD) / BT) % 2 == 1;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_data[p] = '0;
      m_blk[p] = '0;
    end
    for (int c = 0; c < NR; c++) m_duty[c] = 0;
    m_pend = 0; m_pg = '0; m_d = '0; m_b = '0;
    m_cur = '0; m_led = '0; m_auto_q = 0; m_scr = 0;
    m_rgb = '0; cyc = 0;
  endtask

  // Compare current cycle, then advance model and DUT by one cycle.
  task automatic step();
    bit tk, ph, acc;
    logic [NL-1:0] nl;
    logic [3*NR-1:0] nr;
    int md, lv;
    tk = (cyc % TD) == TD - 1;
    ph = phase(cyc);
    check("m_tick", 32'(tick), 32'(tk));
    check("m_ready", 32'(wr_ready), 32'(!m_pend));
    check("m_cur", 32'(cur_page), 32'(m_cur));
    check("m_led", 32'(led), 32'(m_led));
    check("m_rgb", 32'(led_rgb), 32'(m_rgb));
    nl = m_data[m_cur] & ~(m_blk[m_cur] & {NL{ph}});
    nr = '0;
    for (int c = 0; c < NR; c++) begin
      md = int'(rgb_mode[2*c +: 2]);
      lv = int'(rgb_level[PB*c +: PB]);
      if ((cyc % 256) < m_duty[c]) nr[3*c +: 3] = rgb_color[3*c +: 3];
      case (md)
        0: m_duty[c] = 0;
        1: m_duty[c] = lv;
        2: m_duty[c] = ph ? 0 : lv;
        default: m_duty[c] = (lv * tri_ramp(cyc / TD)) / 256;
      endcase
    end
    acc = wr_valid && !m_pend;
    if (tk && m_pend) begin
      m_data[m_pg] = m_d;
      m_blk[m_pg] = m_b;
      m_pend = 0;
    end
    if (acc) begin
      m_pend = 1; m_pg = wr_page; m_d = wr_data; m_b = wr_blink;
    end
    if (!auto_scroll) m_cur = page_sel;
    else if (!m_auto_q) m_scr = 0;
    else if (tk) begin
      m_scr++;
      if (m_scr == ST) begin
        m_scr = 0;
        m_cur = m_cur + 3'd1;
      end
    end
    m_auto_q = auto_scroll;
    m_led = nl;
    m_rgb = nr;
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    @(negedge clk);
    check("rst_led", 32'(led), 0);
    check("rst_rgb", 32'(led_rgb), 0);
    check("rst_cur", 32'(cur_page), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_ready", 32'(wr_ready), 1);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int rep;
    bit wv;
    logic [PW-1:0] pg;
    logic [NL-1:0] d;
    logic [NL-1:0] b;
    logic [PW-1:0] psel;
    logic [NL-1:0] eled;
    logic [PW-1:0] ecur;
    bit erdy;
  } vec_t;

  vec_t vecs [18];
  int e;
  int on_cnt;

  initial begin
    vecs[0]  = '{1, 1'b1, 3'd0, 16'h00FF, 16'h0000, 3'd0, 16'h0000, 3'd0, 1'b1};
    vecs[1]  = '{3, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 3'd0, 1'b0};
    vecs[2]  = '{1, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 3'd0, 1'b1};
    vecs[3]  = '{1, 1'b1, 3'd0, 16'h00FF, 16'h000F, 3'd0, 16'h00FF, 3'd0, 1'b1};
    vecs[4]  = '{2, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h00FF, 3'd0, 1'b0};
    vecs[5]  = '{1, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h00FF, 3'd0, 1'b1};
    vecs[6]  = '{8, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h00F0, 3'd0, 1'b1};
    vecs[7]  = '{8, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h00FF, 3'd0, 1'b1};
    vecs[8]  = '{4, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h00F0, 3'd0, 1'b1};
    vecs[9]  = '{2, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h00F0, 3'd0, 1'b1};
    vecs[10] = '{1, 1'b1, 3'd0, 16'h1234, 16'h0000, 3'd0, 16'h00F0, 3'd0, 1'b1};
    vecs[11] = '{1, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h00F0, 3'd0, 1'b0};
    vecs[12] = '{3, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h00FF, 3'd0, 1'b0};
    vecs[13] = '{1, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h00FF, 3'd0, 1'b1};
    vecs[14] = '{1, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 16'h1234, 3'd0, 1'b1};
    vecs[15] = '{1, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd5, 16'h1234, 3'd0, 1'b1};
    vecs[16] = '{1, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd5, 16'h1234, 3'd5, 1'b1};
    vecs[17] = '{1, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd5, 16'h0000, 3'd5, 1'b1};

    @(negedge clk);
    reset_dut();

    // Writes, blink, accept-on-tick and page select.
    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        wr_valid = vecs[i].wv;
        wr_page  = vecs[i].pg;
        wr_data  = vecs[i].d;
        wr_blink = vecs[i].b;
        page_sel = vecs[i].psel;
        check("tbl_tick", 32'(tick), 32'((cyc % TD) == TD - 1));
        check("tbl_led", 32'(led), 32'(vecs[i].eled));
        check("tbl_cur", 32'(cur_page), 32'(vecs[i].ecur));
        check("tbl_ready", 32'(wr_ready), 32'(vecs[i].erdy));
        step();
      end
    end
    wr_valid = 1'b0;

    // Auto-scroll from page 5 with wrap, then back to manual.
    e = cyc;
    auto_scroll = 1'b1;
    while (cyc < e + 20) begin
      check("scroll_cur", 32'(cur_page), 32'((5 + cyc / TD - (e + 1) / TD) % NP));
      step();
    end
    auto_scroll = 1'b0;
    page_sel = 3'd3;
    step();
    check("manual_sel", 32'(cur_page), 3);
    for (int i = 0; i < 6; i++) begin
      step();
      check("manual_stable", 32'(cur_page), 3);
    end

    // Reset while a write is staged: the entry must be lost.
    while ((cyc % TD) != 0) step();
    wr_valid = 1'b1; wr_page = 3'd3; wr_data = 16'hFFFF; wr_blink = '0;
    step();
    wr_valid = 1'b0;
    check("stage_busy", 32'(wr_ready), 0);
    reset_dut();

    // RGB: solid duty count, then breathe peak and descent.
    rgb_mode = 4'b10_01;
    rgb_color = 6'b010_100;
    rgb_level = {8'd200, 8'd64};
    on_cnt = 0;
    while (cyc < 1300) begin
      if (cyc >= 2 && cyc < 258 && led_rgb[2]) on_cnt++;
      if (cyc == 12) check("reset_discard", 32'(led), 0);
      if (cyc == 258) begin
        check("solid_duty", 32'(on_cnt), 64);
        rgb_mode[1:0] = 2'd3;
        rgb_color[2:0] = 3'b111;
        rgb_level[7:0] = 8'd255;
      end
      if (cyc == 1022) check("breathe_peak", 32'(led_rgb[2:0]), 7);
      if (cyc == 1278) check("breathe_descend", 32'(led_rgb[2:0]), 0);
      step();
    end

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_page  = PW'($urandom_range(0, NP - 1));
      wr_data  = NL'($urandom);
      wr_blink = NL'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) page_sel = PW'($urandom_range(0, NP - 1));
      if ($urandom_range(0, 63) == 0 && (cyc % TD) != TD - 1)
        auto_scroll = ~auto_scroll;
      if ($urandom_range(0, 31) == 0) begin
        rgb_mode  = (2*NR)'($urandom);
        rgb_color = (3*NR)'($urandom);
        rgb_level = (PB*NR)'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
